forwarding_hazard_unit: RTL and testbench

Tracks the register tags of in-flight instructions through the EXE, MEM and WB slots and drives the operand-source selects that steer the EXE-stage forwarding multiplexers. It also raises the ID-stage stall for load-use and, when forwarding is disabled, for any read-after-write hazard. It sits beside the pipeline and is clocked with it. It does not see data values; only register numbers and control bits travel through it.

---
 rtl/forwarding_hazard_unit_pkg.sv | 15 +
 rtl/forwarding_hazard_unit_fwd_sel_gen.sv | 41 ++++
 rtl/forwarding_hazard_unit.sv | 164 ++++++++++++++++
 tb/tb_forwarding_hazard_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared constants for the forwarding/hazard unit: operand-source select
// encoding and the default register-number width.
package forwarding_hazard_unit_pkg;

   localparam int unsigned REG_ADDR_LEN = 4;
   localparam int unsigned FWD_SEL_W    = 2;

   // Operand source steering for the EXE-stage forwarding multiplexers.
   typedef enum logic [FWD_SEL_W-1:0] {
      FWD_SEL_REG = 2'd0,  // register-file read value
      FWD_SEL_MEM = 2'd1,  // ALU result currently in the MEM slot
      FWD_SEL_WB  = 2'd2   // value being written back from the WB slot
   } fwd_sel_e;

endpackage : forwarding_hazard_unit_pkg

// File: rtl/forwarding_hazard_unit_fwd_sel_gen.sv
// Forwarding select generator for one EXE source operand. MEM is checked
// before WB so the newest in-flight value wins.
module fwd_sel_gen
   import forwarding_hazard_unit_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = REG_ADDR_LEN
) (
   input  logic [REG_ADDR_W-1:0] i_src,
   input  logic                  i_use,
   input  logic                  i_mem_valid,
   input  logic                  i_mem_wb_en,
   input  logic [REG_ADDR_W-1:0] i_mem_dest,
   input  logic                  i_wb_valid,
   input  logic                  i_wb_wb_en,
   input  logic [REG_ADDR_W-1:0] i_wb_dest,
   input  logic                  i_forward_en,
   output logic [FWD_SEL_W-1:0]  o_sel
);

   logic     w_mem_hit;
   logic     w_wb_hit;
   fwd_sel_e w_sel;

   assign w_mem_hit = i_mem_valid & i_mem_wb_en & (i_mem_dest == i_src);
   assign w_wb_hit  = i_wb_valid  & i_wb_wb_en  & (i_wb_dest  == i_src);

   // Priority select: disabled or unused operand reads the register file.
   always_comb begin
      w_sel = FWD_SEL_REG;
      if (i_forward_en && i_use) begin
         if (w_mem_hit) begin
            w_sel = FWD_SEL_MEM;
         end else if (w_wb_hit) begin
            w_sel = FWD_SEL_WB;
         end
      end
   end

   assign o_sel = w_sel;

endmodule : fwd_sel_gen

// File: rtl/forwarding_hazard_unit.sv
// Tag tracker for the EXE/MEM/WB slots. Drives the EXE forwarding selects,
// the ID-stage hazard stall and a saturating stall-cycle counter.
module forwarding_hazard_unit
   import forwarding_hazard_unit_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = REG_ADDR_LEN,
   parameter int unsigned PERF_W     = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  forward_en,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_src1,
   input  logic [REG_ADDR_W-1:0] id_src2,
   input  logic                  id_two_src,
   input  logic [REG_ADDR_W-1:0] id_dest,
   input  logic                  id_wb_en,
   input  logic                  id_mem_read,
   input  logic                  branch_taken,
   output logic [1:0]            alu_mux_src_1_sel,
   output logic [1:0]            alu_mux_src_2_sel,
   output logic                  hazard_stall,
   output logic [PERF_W-1:0]     stall_count
);

   localparam logic [PERF_W-1:0] LP_CNT_ONE = PERF_W'(1);

   // EXE slot holds the full tag; MEM and WB carry only the fields that
   // forwarding and stall detection consult once an instruction leaves EXE.
   logic                  r_exe_valid;
   logic [REG_ADDR_W-1:0] r_exe_src1;
   logic [REG_ADDR_W-1:0] r_exe_src2;
   logic                  r_exe_two_src;
   logic [REG_ADDR_W-1:0] r_exe_dest;
   logic                  r_exe_wb_en;
   logic                  r_exe_mem_read;

   logic                  r_mem_valid;
   logic [REG_ADDR_W-1:0] r_mem_dest;
   logic                  r_mem_wb_en;

   logic                  r_wb_valid;
   logic [REG_ADDR_W-1:0] r_wb_dest;
   logic                  r_wb_wb_en;

   logic [PERF_W-1:0]     r_stall_count;

   logic                  w_exe_hit;
   logic                  w_mem_hit;
   logic                  w_load_use;
   logic                  w_raw;
   logic                  w_stall;
   logic                  w_exe_load;

   // ID sources against the EXE and MEM destinations.
   always_comb begin
      w_exe_hit = 1'b0;
      w_mem_hit = 1'b0;
      if (r_exe_valid && r_exe_wb_en) begin
         w_exe_hit = (r_exe_dest == id_src1) | (id_two_src & (r_exe_dest == id_src2));
      end
      if (r_mem_valid && r_mem_wb_en) begin
         w_mem_hit = (r_mem_dest == id_src1) | (id_two_src & (r_mem_dest == id_src2));
      end
   end

   // Load-use with forwarding; any EXE/MEM RAW without it. WB is safe because
   // the register file writes before it reads. A taken branch flushes ID.
   always_comb begin
      w_load_use = id_valid & r_exe_mem_read & w_exe_hit;
      w_raw      = id_valid & (w_exe_hit | w_mem_hit);
      w_stall    = 1'b0;
      if (!branch_taken) begin
         w_stall = forward_en ? w_load_use : w_raw;
      end
      w_exe_load = id_valid & ~w_stall & ~branch_taken;
   end

   assign hazard_stall = w_stall;
   assign stall_count  = r_stall_count;

   // Advance tags one slot per clock; EXE takes ID or a bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_exe_valid    <= 1'b0;
         r_exe_src1     <= '0;
         r_exe_src2     <= '0;
         r_exe_two_src  <= 1'b0;
         r_exe_dest     <= '0;
         r_exe_wb_en    <= 1'b0;
         r_exe_mem_read <= 1'b0;
         r_mem_valid    <= 1'b0;
         r_mem_dest     <= '0;
         r_mem_wb_en    <= 1'b0;
         r_wb_valid     <= 1'b0;
         r_wb_dest      <= '0;
         r_wb_wb_en     <= 1'b0;
      end else begin
         r_wb_valid  <= r_mem_valid;
         r_wb_dest   <= r_mem_dest;
         r_wb_wb_en  <= r_mem_wb_en;
         r_mem_valid <= r_exe_valid;
         r_mem_dest  <= r_exe_dest;
         r_mem_wb_en <= r_exe_wb_en;
         if (w_exe_load) begin
            r_exe_valid    <= 1'b1;
            r_exe_src1     <= id_src1;
            r_exe_src2     <= id_src2;
            r_exe_two_src  <= id_two_src;
            r_exe_dest     <= id_dest;
            r_exe_wb_en    <= id_wb_en;
            r_exe_mem_read <= id_mem_read;
         end else begin
            r_exe_valid    <= 1'b0;
            r_exe_src1     <= '0;
            r_exe_src2     <= '0;
            r_exe_two_src  <= 1'b0;
            r_exe_dest     <= '0;
            r_exe_wb_en    <= 1'b0;
            r_exe_mem_read <= 1'b0;
         end
      end
   end

   // Saturating count of stalled cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_count <= '0;
      end else if (w_stall && (r_stall_count != '1)) begin
         r_stall_count <= r_stall_count + LP_CNT_ONE;
      end
   end

   fwd_sel_gen #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_sel_rn (
      .i_src        (r_exe_src1),
      .i_use        (r_exe_valid),
      .i_mem_valid  (r_mem_valid),
      .i_mem_wb_en  (r_mem_wb_en),
      .i_mem_dest   (r_mem_dest),
      .i_wb_valid   (r_wb_valid),
      .i_wb_wb_en   (r_wb_wb_en),
      .i_wb_dest    (r_wb_dest),
      .i_forward_en (forward_en),
      .o_sel        (alu_mux_src_1_sel)
   );

   fwd_sel_gen #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_sel_rm (
      .i_src        (r_exe_src2),
      .i_use        (r_exe_valid & r_exe_two_src),
      .i_mem_valid  (r_mem_valid),
      .i_mem_wb_en  (r_mem_wb_en),
      .i_mem_dest   (r_mem_dest),
      .i_wb_valid   (r_wb_valid),
      .i_wb_wb_en   (r_wb_wb_en),
      .i_wb_dest    (r_wb_dest),
      .i_forward_en (forward_en),
      .o_sel        (alu_mux_src_2_sel)
   );

endmodule : forwarding_hazard_unit

// File: tb/tb_forwarding_hazard_unit.sv
// Directed bench for forwarding_hazard_unit. A second instance with a 4-bit
// counter shares every input so saturation is reachable in a few cycles.
module tb_forwarding_hazard_unit;

   logic       clk;
   logic       rst;
   logic       forward_en;
   logic       id_valid;
   logic [3:0] id_src1;
   logic [3:0] id_src2;
   logic       id_two_src;
   logic [3:0] id_dest;
   logic       id_wb_en;
   logic       id_mem_read;
   logic       branch_taken;

   logic [1:0]  sel1, sel2;
   logic        stall;
   logic [15:0] cnt;
   logic [1:0]  s_sel1, s_sel2;
   logic        s_stall;
   logic [3:0]  s_cnt;

   int vectors = 0;
   int miscompares = 0;

   forwarding_hazard_unit #(.REG_ADDR_W(4), .PERF_W(16)) u_dut (
      .clk(clk), .rst(rst), .forward_en(forward_en), .id_valid(id_valid),
      .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
      .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
      .branch_taken(branch_taken), .alu_mux_src_1_sel(sel1),
      .alu_mux_src_2_sel(sel2), .hazard_stall(stall), .stall_count(cnt)
   );

   forwarding_hazard_unit #(.REG_ADDR_W(4), .PERF_W(4)) u_sat (
      .clk(clk), .rst(rst), .forward_en(forward_en), .id_valid(id_valid),
      .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
      .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
      .branch_taken(branch_taken), .alu_mux_src_1_sel(s_sel1),
      .alu_mux_src_2_sel(s_sel2), .hazard_stall(s_stall), .stall_count(s_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                         input logic two, input logic [3:0] d, input logic wb,
                         input logic mr);
      id_valid = v; id_src1 = s1; id_src2 = s2; id_two_src = two;
      id_dest = d; id_wb_en = wb; id_mem_read = mr;
      #1;
   endtask

   task automatic drain();
      set_id(0, 0, 0, 0, 0, 0, 0);
      repeat (3) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      vectors++; if (sel1 !== 2'd0) begin miscompares++; $display("FAIL reset_sel1 got %0d exp 0", sel1); end
      vectors++; if (sel2 !== 2'd0) begin miscompares++; $display("FAIL reset_sel2 got %0d exp 0", sel2); end
      vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %0b exp 0", stall); end
      vectors++; if (cnt !== 16'd0) begin miscompares++; $display("FAIL reset_cnt got %0d exp 0", cnt); end
      vectors++; if (s_cnt !== 4'd0) begin miscompares++; $display("FAIL reset_scnt got %0d exp 0", s_cnt); end
      rst = 1'b0;
   endtask

   task automatic test_forward();
      forward_en = 1'b1;
      set_id(1, 7, 8, 1, 1, 1, 0);             // ADD r1,r7,r8
      vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL fwd_stall0 got %0b exp 0", stall); end
      tick();
      set_id(1, 1, 3, 1, 2, 1, 0);             // SUB r2,r1,r3
      vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL fwd_stall1 got %0b exp 0", stall); end
      vectors++; if (sel1 !== 2'd0) begin miscompares++; $display("FAIL fwd_add_sel1 got %0d exp 0", sel1); end
      tick();
      set_id(1, 1, 1, 1, 9, 1, 0);             // EOR r9,r1,r1
      vectors++; if (sel1 !== 2'd1) begin miscompares++; $display("FAIL fwd_mem_sel1 got %0d exp 1", sel1); end
      vectors++; if (sel2 !== 2'd0) begin miscompares++; $display("FAIL fwd_mem_sel2 got %0d exp 0", sel2); end
      vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL fwd_stall2 got %0b exp 0", stall); end
      forward_en = 1'b0; #1;
      vectors++; if (sel1 !== 2'd0) begin miscompares++; $display("FAIL fwd_disabled_sel1 got %0d exp 0", sel1); end
      forward_en = 1'b1; #1;
      tick();
      set_id(0, 0, 0, 0, 0, 0, 0);
      vectors++; if (sel1 !== 2'd2) begin miscompares++; $display("FAIL fwd_wb_sel1 got %0d exp 2", sel1); end
      vectors++; if (sel2 !== 2'd2) begin miscompares++; $display("FAIL fwd_wb_sel2 got %0d exp 2", sel2); end
      vectors++; if (cnt !== 16'd0) begin miscompares++; $display("FAIL fwd_cnt got %0d exp 0", cnt); end
      drain();
   endtask

   task automatic test_mem_priority();
      set_id(1, 0, 0, 0, 4, 1, 0); tick();     // ADD r4
      set_id(1, 5, 0, 0, 4, 1, 0); tick();     // MOV r4,r5
      set_id(1, 4, 4, 1, 10, 1, 0); tick();    // SUB r10,r4,r4
      set_id(1, 0, 4, 0, 11, 1, 0);            // reads r0 only; src2 field = r4
      vectors++; if (sel1 !== 2'd1) begin miscompares++; $display("FAIL prio_sel1 got %0d exp 1", sel1); end
      vectors++; if (sel2 !== 2'd1) begin miscompares++; $display("FAIL prio_sel2 got %0d exp 1", sel2); end
      tick();
      vectors++; if (sel1 !== 2'd0) begin miscompares++; $display("FAIL onesrc_sel1 got %0d exp 0", sel1); end
      vectors++; if (sel2 !== 2'd0) begin miscompares++; $display("FAIL onesrc_sel2 got %0d exp 0", sel2); end
      drain();
   endtask

   task automatic test_r15();
      set_id(1, 0, 0, 0, 15, 0, 0); tick();    // PC write, no wb_en
      set_id(1, 15, 0, 0, 3, 0, 0); tick();    // reads r15
      vectors++; if (sel1 !== 2'd0) begin miscompares++; $display("FAIL pc_nofwd_sel1 got %0d exp 0", sel1); end
      set_id(1, 0, 0, 0, 15, 1, 0); tick();    // ADD r15
      set_id(1, 15, 15, 1, 3, 1, 0);
      vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL r15_stall got %0b exp 0", stall); end
      tick();
      vectors++; if (sel1 !== 2'd1) begin miscompares++; $display("FAIL r15_sel1 got %0d exp 1", sel1); end
      vectors++; if (sel2 !== 2'd1) begin miscompares++; $display("FAIL r15_sel2 got %0d exp 1", sel2); end
      drain();
   endtask

   task automatic test_load_use();
      set_id(1, 6, 0, 0, 5, 1, 1); tick();     // LDR r5,[r6]
      set_id(1, 2, 5, 0, 7, 1, 0);             // src2 = r5 but not read
      vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL lu_onesrc_stall got %0b exp 0", stall); end
      set_id(1, 5, 2, 1, 7, 1, 0);             // ADD r7,r5,r2
      vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL lu_stall got %0b exp 1", stall); end
      tick();
      vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL lu_stall_end got %0b exp 0", stall); end
      vectors++; if (cnt !== 16'd1) begin miscompares++; $display("FAIL lu_cnt got %0d exp 1", cnt); end
      vectors++; if (sel1 !== 2'd0) begin miscompares++; $display("FAIL lu_bubble_sel1 got %0d exp 0", sel1); end
      tick();
      set_id(0, 0, 0, 0, 0, 0, 0);
      vectors++; if (sel1 !== 2'd2) begin miscompares++; $display("FAIL lu_sel1 got %0d exp 2", sel1); end
      vectors++; if (sel2 !== 2'd0) begin miscompares++; $display("FAIL lu_sel2 got %0d exp 0", sel2); end
      drain();
   endtask

   task automatic test_no_forward();
      forward_en = 1'b0;
      set_id(1, 2, 3, 1, 1, 1, 0); tick();     // ADD r1,r2,r3
      set_id(1, 1, 1, 1, 6, 1, 0);             // ORR r6,r1,r1
      vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL nf_stall0 got %0b exp 1", stall); end
      tick();
      vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL nf_stall1 got %0b exp 1", stall); end
      tick();
      vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL nf_stall2 got %0b exp 0", stall); end
      vectors++; if (cnt !== 16'd3) begin miscompares++; $display("FAIL nf_cnt got %0d exp 3", cnt); end
      tick();
      set_id(0, 0, 0, 0, 0, 0, 0);
      vectors++; if ({sel1, sel2} !== 4'd0) begin miscompares++; $display("FAIL nf_sels got %0d/%0d exp 0/0", sel1, sel2); end
      drain();
      forward_en = 1'b1;
   endtask

   task automatic test_branch_flush();
      set_id(1, 6, 0, 0, 5, 1, 1); tick();     // LDR r5
      set_id(1, 5, 0, 0, 8, 1, 0);
      vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL br_prestall got %0b exp 1", stall); end
      branch_taken = 1'b1; #1;
      vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL br_stall got %0b exp 0", stall); end
      tick();
      branch_taken = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0);
      vectors++; if (sel1 !== 2'd0) begin miscompares++; $display("FAIL br_bubble_sel1 got %0d exp 0", sel1); end
      vectors++; if (cnt !== 16'd3) begin miscompares++; $display("FAIL br_cnt got %0d exp 3", cnt); end
      drain();
   endtask

   task automatic test_saturation();
      forward_en = 1'b0;
      for (int i = 0; i < 7; i++) begin
         set_id(1, 2, 3, 0, 1, 1, 0); tick();  // producer r1
         set_id(1, 1, 0, 0, 0, 0, 0);          // consumer, no writeback
         repeat (3) tick();
         if (i == 5) begin
            vectors++; if (s_cnt !== 4'hF) begin miscompares++; $display("FAIL sat_reach got %0d exp 15", s_cnt); end
            vectors++; if (cnt !== 16'd15) begin miscompares++; $display("FAIL sat_wide15 got %0d exp 15", cnt); end
         end
      end
      vectors++; if (s_cnt !== 4'hF) begin miscompares++; $display("FAIL sat_hold got %0d exp 15", s_cnt); end
      vectors++; if (cnt !== 16'd17) begin miscompares++; $display("FAIL sat_wide17 got %0d exp 17", cnt); end
      drain();
   endtask

   task automatic test_reset_mid_stall();
      set_id(1, 2, 3, 0, 1, 1, 0); tick();
      set_id(1, 1, 0, 0, 0, 0, 0);
      vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL rs_prestall got %0b exp 1", stall); end
      rst = 1'b1;
      tick();
      vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL rs_stall got %0b exp 0", stall); end
      vectors++; if ({sel1, sel2} !== 4'd0) begin miscompares++; $display("FAIL rs_sels got %0d/%0d exp 0/0", sel1, sel2); end
      vectors++; if (cnt !== 16'd0) begin miscompares++; $display("FAIL rs_cnt got %0d exp 0", cnt); end
      vectors++; if (s_cnt !== 4'd0) begin miscompares++; $display("FAIL rs_scnt got %0d exp 0", s_cnt); end
      tick();
      vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL rs_held_stall got %0b exp 0", stall); end
      rst = 1'b0; #1;
      vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL rs_after_stall got %0b exp 0", stall); end
      tick();
      set_id(0, 0, 0, 0, 0, 0, 0);
      vectors++; if (cnt !== 16'd0) begin miscompares++; $display("FAIL rs_after_cnt got %0d exp 0", cnt); end
      drain();
      forward_en = 1'b1;
   endtask

   initial begin
      rst = 1'b1; forward_en = 1'b1; branch_taken = 1'b0;
      id_valid = 1'b0; id_src1 = '0; id_src2 = '0; id_two_src = 1'b0;
      id_dest = '0; id_wb_en = 1'b0; id_mem_read = 1'b0;
      test_reset();
      test_forward();
      test_mem_priority();
      test_r15();
      test_load_use();
      test_no_forward();
      test_branch_flush();
      test_saturation();
      test_reset_mid_stall();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_forwarding_hazard_unit
